serial_operand_sender: RTL
==========================

SERIAL_OPERAND_SENDER -- requirements
Module: serial_operand_sender

Interface
REQ-001 SHALL have parameter MULTIPLICAND_WIDTH, default 4, width of parallel multiplicand passed to the MAC.
REQ-002 SHALL have parameter MULTIPLIER_WIDTH, default 4 (min 1), number of multiplier bits serialised LSB-first.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT_DONE cycle limit; used only when SEROP_DONE_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  operand pair offered upstream.
REQ-007 SHALL have port in_ready  out  1  sender can accept an operand pair.
REQ-008 SHALL have port in_multiplicand  in  MULTIPLICAND_WIDTH  multiplicand of offered pair.
REQ-009 SHALL have port in_multiplier  in  MULTIPLIER_WIDTH  multiplier of offered pair.
REQ-010 SHALL have port in_clear  in  1  clear MAC accumulator before this operation.
REQ-011 SHALL have port mac_start  out  1  one-cycle start pulse to MAC.
REQ-012 SHALL have port mac_clear_acc  out  1  one-cycle accumulator clear to MAC.
REQ-013 SHALL have port mac_multiplicand  out  MULTIPLICAND_WIDTH  held multiplicand to MAC.
REQ-014 SHALL have port mac_serial_bit  out  1  serial multiplier bit to MAC.
REQ-015 SHALL have port mac_done  in  1  MAC completion indication.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port op_done  out  1  one-cycle pulse per completed operation.
REQ-018 SHALL have port timeout_err  out  1  sticky MAC-timeout flag (tied 0 when feature compiled out).

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, SEND, WAIT_DONE; all outputs registered.
REQ-020 SHALL drive in_ready=1 only in IDLE; transfer occurs on an edge with in_valid&&in_ready.
REQ-021 On transfer SHALL latch multiplicand, multiplier, in_clear; next state CLEAR if in_clear else SEND.
REQ-022 CLEAR SHALL last exactly one cycle with mac_clear_acc=1, mac_start=0, then go to SEND.
REQ-023 SEND SHALL last exactly MULTIPLIER_WIDTH cycles; cycle k drives mac_serial_bit=multiplier[k], k=0..MULTIPLIER_WIDTH-1.
REQ-024 mac_start SHALL be 1 only in SEND cycle 0, coincident with multiplier[0].
REQ-025 Latency transfer-edge to mac_start high SHALL be 1 cycle without clear, 2 cycles with clear.
REQ-026 mac_multiplicand SHALL be stable from first SEND cycle until WAIT_DONE exit.
REQ-027 mac_serial_bit SHALL be 0 outside SEND.
REQ-028 WAIT_DONE SHALL wait for mac_done=1; on the edge sampling it SHALL pulse op_done one cycle and return to IDLE.
REQ-029 mac_done while in IDLE, CLEAR or SEND SHALL be ignored.
REQ-030 MULTIPLIER_WIDTH=1 SHALL give a one-cycle SEND carrying mac_start and bit 0 together.
REQ-031 Back-to-back: with in_valid held high, next transfer SHALL occur on the first IDLE edge after op_done.

Reset
REQ-032 rst low SHALL immediately force IDLE, bit counter 0, in_ready=0 while asserted, all other outputs 0, timeout_err 0.
REQ-033 Reset mid-SEND or mid-WAIT_DONE SHALL abandon the operation with no op_done; in_ready=1 first cycle after release.

Configuration
REQ-034 With macro SEROP_DONE_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE; after TIMEOUT_CYCLES cycles without mac_done SHALL set timeout_err, return to IDLE, no op_done.
REQ-035 timeout_err SHALL remain set until reset or next transfer.
REQ-036 Without SEROP_DONE_TIMEOUT_EN, no counter SHALL exist, WAIT_DONE waits indefinitely, timeout_err constant 0.

Verification
REQ-037 2x6, in_clear=1 -> clear pulse, then start with bits 0,1,1,0 over 4 cycles; mac_done -> op_done pulse.
REQ-038 3x4, in_clear=0 -> no clear pulse; start 1 cycle after transfer; bits 0,0,1,0; mac_multiplicand=3 held.
REQ-039 FxF, in_valid held high across two ops -> bits 1,1,1,1 each; second transfer on first IDLE edge after op_done.
REQ-040 rst low in SEND cycle 2 -> outputs 0 at once, no op_done; in_ready=1 after release.
REQ-041 SEROP_DONE_TIMEOUT_EN, TIMEOUT_CYCLES=8, mac_done never high -> timeout_err=1 after 8 WAIT_DONE cycles, IDLE, no op_done.
REQ-042 mac_done pulsed during SEND -> ignored; operation completes only on later mac_done in WAIT_DONE.

Source files
------------

// File: rtl/serial_operand_sender.sv
// serial_operand_sender: accepts a multiplicand/multiplier pair, optionally pulses an
// accumulator clear, then streams the multiplier LSB-first to a serial MAC while holding
// the multiplicand. It then waits for the MAC to report completion.
// Optional feature: define SEROP_DONE_TIMEOUT_EN to bound the WAIT_DONE state to
// TIMEOUT_CYCLES cycles and raise the sticky timeout_err flag on expiry.
module serial_operand_sender #(
    parameter int unsigned MULTIPLICAND_WIDTH = 4,
    parameter int unsigned MULTIPLIER_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MULTIPLICAND_WIDTH-1:0] in_multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]   in_multiplier,
    input  logic                          in_clear,
    output logic                          mac_start,
    output logic                          mac_clear_acc,
    output logic [MULTIPLICAND_WIDTH-1:0] mac_multiplicand,
    output logic                          mac_serial_bit,
    input  logic                          mac_done,
    output logic                          busy,
    output logic                          op_done,
    output logic                          timeout_err
);

    localparam int unsigned CntW = (MULTIPLIER_WIDTH > 1) ? $clog2(MULTIPLIER_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(MULTIPLIER_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StSend,
        StWaitDone
    } state_e;

    state_e                        state_q, state_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [MULTIPLICAND_WIDTH-1:0] mcand_q, mcand_d;
    logic [MULTIPLIER_WIDTH-1:0]   mult_q, mult_d;
    logic                          in_ready_q, in_ready_d;
    logic                          start_q, start_d;
    logic                          clear_q, clear_d;
    logic                          ser_q, ser_d;
    logic                          busy_q, busy_d;
    logic                          op_done_q, op_done_d;
    logic                          transfer;

`ifdef SEROP_DONE_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_err_q, tmo_err_d;
`endif

    // in_ready_q is only ever high in IDLE, so it alone qualifies a transfer.
    assign transfer = in_valid && in_ready_q;

    // Next-state logic; every output is derived from the next state so it is registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        op_done_d = 1'b0;
`ifdef SEROP_DONE_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    mcand_d = in_multiplicand;
                    mult_d  = in_multiplier;
                    cnt_d   = '0;
                    state_d = in_clear ? StClear : StSend;
`ifdef SEROP_DONE_TIMEOUT_EN
                    tmo_err_d = 1'b0;
`endif
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                // mac_done is deliberately ignored until the whole multiplier is out.
                if (cnt_q == LastBit) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
`ifdef SEROP_DONE_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (mac_done) begin
                    op_done_d = 1'b1;
                    state_d   = StIdle;
                end
`ifdef SEROP_DONE_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    tmo_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
        clear_d    = (state_d == StClear);
        start_d    = (state_d == StSend) && (cnt_d == '0);
        ser_d      = (state_d == StSend) ? mult_d[cnt_d] : 1'b0;
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mult_q     <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            ser_q      <= 1'b0;
            busy_q     <= 1'b0;
            op_done_q  <= 1'b0;
`ifdef SEROP_DONE_TIMEOUT_EN
            tmo_q      <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            in_ready_q <= in_ready_d;
            start_q    <= start_d;
            clear_q    <= clear_d;
            ser_q      <= ser_d;
            busy_q     <= busy_d;
            op_done_q  <= op_done_d;
`ifdef SEROP_DONE_TIMEOUT_EN
            tmo_q      <= tmo_d;
            tmo_err_q  <= tmo_err_d;
`endif
        end
    end

    assign in_ready         = in_ready_q;
    assign mac_start        = start_q;
    assign mac_clear_acc    = clear_q;
    assign mac_multiplicand = mcand_q;
    assign mac_serial_bit   = ser_q;
    assign busy             = busy_q;
    assign op_done          = op_done_q;

`ifdef SEROP_DONE_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`else
    // No timeout hardware in this build; the parameter is intentionally unused.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_err           = 1'b0;
`endif

endmodule
